x_emac_miim_host: RTL and testbench
===================================

Name: x_emac_miim_host

Overview:
Parametrised host-side MIIM (MDIO, IEEE 802.3 clause 22) management controller serving NUM_EMAC EMAC channels from one host bus. It converts single HOSTREQ host transactions into serial MDC/MDIO frames on the selected channel, and returns read data with a ready handshake. It generalises the fixed two-EMAC management port: channel count is configurable, the MDC divider and preamble suppression are programmable, and illegal requests are flagged with an error output.

Parameters:
NUM_EMAC, 2, number of EMAC/PHY management channels (1..8).
CLK_DIV, 10, MDC half-period in HOSTCLK cycles (>=2).
PREAMBLE_EN, 1, 1 = send 32-bit all-ones preamble; 0 = suppressed (32-bit frame).

Ports:
HOSTCLK  in  1  block clock.
RESET  in  1  asynchronous, active-high reset.
HOSTREQ  in  1  request strobe, sampled when HOSTMIIMRDY=1.
HOSTMIIMSEL  in  1  1 = MIIM access; requests with 0 are ignored.
HOSTEMACSEL  in  SELW=max(1,$clog2(NUM_EMAC))  target channel index.
HOSTOPCODE  in  2  2'b01 write, 2'b10 read; 00/11 illegal.
HOSTADDR  in  10  [9:5] PHYAD, [4:0] REGAD.
HOSTWRDATA  in  16  write data.
HOSTRDDATA  out  16  read data.
HOSTMIIMRDY  out  1  1 = idle, able to accept a request.
HOSTMIIMERR  out  1  one-cycle pulse on a rejected request.
EMACPHYMCLKOUT  out  NUM_EMAC  per-channel MDC.
EMACPHYMDOUT  out  NUM_EMAC  per-channel MDIO output data.
EMACPHYMDTRI  out  NUM_EMAC  per-channel MDIO tristate, 1 = released.
PHYEMACMDIN  in  NUM_EMAC  per-channel MDIO input.

Behaviour:
- Clock/reset: single clock HOSTCLK; RESET is asynchronous, active-high.
- Reset values, applied immediately on RESET assertion: HOSTRDDATA=0, HOSTMIIMRDY=1, HOSTMIIMERR=0, all MCLKOUT=0, all MDOUT=1, all MDTRI=1, FSM=IDLE. Asserting RESET mid-frame aborts the frame with no completion and no error.
- Accept: HOSTREQ & HOSTMIIMSEL & HOSTMIIMRDY in cycle 0.
  - Legal opcode and HOSTEMACSEL<NUM_EMAC: latch opcode, address, data and channel. HOSTMIIMRDY=0 from cycle 1.
  - Otherwise: HOSTMIIMERR=1 in cycle 1 only, HOSTMIIMRDY stays 1, no MDC activity.
- HOSTREQ while busy: ignored. No queueing and no error.
- FSM states: IDLE -> SHIFT_LO -> SHIFT_HI -> (SHIFT_LO next bit | DONE) -> IDLE.
  - SHIFT_LO and SHIFT_HI each last CLK_DIV cycles.
  - MDC=0 in SHIFT_LO and 1 in SHIFT_HI.
  - MDOUT/MDTRI update on entry to SHIFT_LO.
  - MDIN is registered on the last cycle of SHIFT_LO, i.e. on the MDC rising edge.
- Frame (NBITS = 64, or 32 when PREAMBLE_EN=0), MSB first:
  - [preamble 32x1], ST=01, OP, PHYAD[4:0], REGAD[4:0], TA, DATA[15:0].
  - Write: TA=10, all bits driven, MDTRI=0 for the whole frame.
  - Read: MDTRI=1 from the TA first bit through DATA; the 16 DATA bits are shifted in from MDIN.
- Completion: DONE lasts 1 cycle (MDC=0, MDTRI=1, MDOUT=1).
  - HOSTMIIMRDY=1 exactly 2 + NBITS*2*CLK_DIV cycles after the accept cycle.
  - A read updates HOSTRDDATA in that same cycle; a write leaves HOSTRDDATA unchanged.
- Unselected channels stay at idle values throughout: MCLKOUT=0, MDOUT=1, MDTRI=1. MDC runs only during a frame.
- Counters:
  - Divider: $clog2(CLK_DIV) bits, reloaded on every phase change.
  - Bit counter: 6 bits, counts down from NBITS-1; leaving SHIFT_HI with count 0 -> DONE.
- A new request is accepted in the same cycle HOSTMIIMRDY returns to 1.

Decomposition:
- Package x_emac_pkg holds:
  - Opcode constants: MIIM_OP_WR=2'b01, MIIM_OP_RD=2'b10.
  - Frame field constants: ST=2'b01, TA_WR=2'b10, PREAMBLE_LEN=32.
  - MIIM FSM state enum.
- Sub-module x_emac_mdc_gen: CLK_DIV divider with enable, producing fall_tick and rise_tick pulses and the MDC level.

Test Plan:
- Write, NUM_EMAC=2, CLK_DIV=2: ch1, PHYAD=5'h01, REGAD=5'h04, data 16'hA5C3 -> ch1 MDOUT = 32x1,01,01,00001,00100,10,1010010111000011; MDTRI=0 throughout; ch0 idle; HOSTMIIMRDY high at cycle 258.
- Read, CLK_DIV=2: ch0, PHY model drives 16'h1234 after TA -> MDTRI=1 from TA; HOSTRDDATA=16'h1234 in cycle 258 with HOSTMIIMRDY=1.
- PREAMBLE_EN=0, CLK_DIV=3: write -> frame starts with 01, 32 bits; HOSTMIIMRDY high at cycle 2+32*6=194.
- Opcode 2'b00, and separately HOSTEMACSEL=3 with NUM_EMAC=3 -> HOSTMIIMERR=1 for 1 cycle; HOSTMIIMRDY stays 1; all MDC stay 0.
- Second HOSTREQ at cycle 10 of a busy write -> ignored; exactly one frame; no error pulse.
- RESET asserted at bit 20 of a read -> same-cycle MDC=0, MDTRI=1, HOSTMIIMRDY=1, HOSTRDDATA=0; a following write completes normally.

Source files
------------

// File: rtl/x_emac_pkg.sv
// rtl/x_emac_pkg.sv - shared MIIM constants and FSM state type
package x_emac_pkg;

    localparam logic [1:0] MIIM_OP_WR = 2'b01;
    localparam logic [1:0] MIIM_OP_RD = 2'b10;

    localparam logic [1:0] ST           = 2'b01;
    localparam logic [1:0] TA_WR        = 2'b10;
    localparam int         PREAMBLE_LEN = 32;

    typedef enum logic [1:0] {
        MIIM_IDLE,
        MIIM_SHIFT_LO,
        MIIM_SHIFT_HI,
        MIIM_DONE
    } miim_state_t;

    function automatic logic miim_op_legal(input logic [1:0] op);
        return (op == MIIM_OP_WR) || (op == MIIM_OP_RD);
    endfunction

endpackage

// File: rtl/x_emac_mdc_gen.sv
// rtl/x_emac_mdc_gen.sv - MDC divider producing phase-end ticks and the MDC level
module x_emac_mdc_gen #(
    parameter int CLK_DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic fall_tick,
    output logic rise_tick,
    output logic mdc
);

    localparam int             DW     = $clog2(CLK_DIV);
    localparam logic [DW-1:0]  RELOAD = DW'(CLK_DIV - 1);

    logic [DW-1:0] cnt;
    logic          terminal;

    // Ticks flag the last cycle of a phase, so the FSM moves on the same edge MDC toggles.
    assign terminal  = en && (cnt == '0);
    assign rise_tick = terminal && !mdc;
    assign fall_tick = terminal && mdc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= RELOAD;
            mdc <= 1'b0;
        end else if (!en) begin
            cnt <= RELOAD;
            mdc <= 1'b0;
        end else if (cnt == '0) begin
            cnt <= RELOAD;
            mdc <= !mdc;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/x_emac_miim_host.sv
// rtl/x_emac_miim_host.sv - multi-channel clause 22 MIIM host controller
module x_emac_miim_host
    import x_emac_pkg::*;
#(
    parameter int NUM_EMAC    = 2,
    parameter int CLK_DIV     = 10,
    parameter int PREAMBLE_EN = 1,
    localparam int SELW = (NUM_EMAC > 1) ? $clog2(NUM_EMAC) : 1
) (
    input  logic                HOSTCLK,
    input  logic                RESET,
    input  logic                HOSTREQ,
    input  logic                HOSTMIIMSEL,
    input  logic [SELW-1:0]     HOSTEMACSEL,
    input  logic [1:0]          HOSTOPCODE,
    input  logic [9:0]          HOSTADDR,
    input  logic [15:0]         HOSTWRDATA,
    output logic [15:0]         HOSTRDDATA,
    output logic                HOSTMIIMRDY,
    output logic                HOSTMIIMERR,
    output logic [NUM_EMAC-1:0] EMACPHYMCLKOUT,
    output logic [NUM_EMAC-1:0] EMACPHYMDOUT,
    output logic [NUM_EMAC-1:0] EMACPHYMDTRI,
    input  logic [NUM_EMAC-1:0] PHYEMACMDIN
);

    localparam int         NBITS   = (PREAMBLE_EN != 0) ? 64 : 32;
    localparam logic [5:0] REL_CNT = 6'd17;

    miim_state_t         state;
    logic [5:0]          bit_cnt;
    logic [5:0]          next_cnt;
    logic [63:0]         frame;
    logic [63:0]         frame_next;
    logic [31:0]         body;
    logic [15:0]         rd_shift;
    logic                is_rd;
    logic                req_rd;
    logic                legal;
    logic                mdin_sel;
    logic [NUM_EMAC-1:0] ch_oh;
    logic [NUM_EMAC-1:0] oh_next;
    logic [NUM_EMAC-1:0] md_out;
    logic [NUM_EMAC-1:0] md_tri;
    logic                fall_tick;
    logic                rise_tick;
    logic                mdc;
    logic                shifting;

    always_comb begin
        oh_next = '0;
        for (int i = 0; i < NUM_EMAC; i++) begin
            oh_next[i] = (int'(HOSTEMACSEL) == i);
        end
    end

    assign req_rd   = (HOSTOPCODE == MIIM_OP_RD);
    assign legal    = miim_op_legal(HOSTOPCODE) && (int'(HOSTEMACSEL) < NUM_EMAC);
    // Released read bits are loaded as ones; MDTRI hides them from the line anyway.
    assign body     = {ST, HOSTOPCODE, HOSTADDR, req_rd ? 2'b11 : TA_WR,
                       req_rd ? 16'hFFFF : HOSTWRDATA};
    assign frame_next = (PREAMBLE_EN != 0) ? {{PREAMBLE_LEN{1'b1}}, body}
                                           : {body, {PREAMBLE_LEN{1'b1}}};
    assign next_cnt = bit_cnt - 6'd1;
    assign mdin_sel = |(PHYEMACMDIN & ch_oh);
    assign shifting = (state == MIIM_SHIFT_LO) || (state == MIIM_SHIFT_HI);

    x_emac_mdc_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_mdc_gen (
        .clk      (HOSTCLK),
        .rst      (RESET),
        .en       (shifting),
        .fall_tick(fall_tick),
        .rise_tick(rise_tick),
        .mdc      (mdc)
    );

    always_ff @(posedge HOSTCLK or posedge RESET) begin
        if (RESET) begin
            state       <= MIIM_IDLE;
            bit_cnt     <= '0;
            frame       <= '0;
            rd_shift    <= '0;
            is_rd       <= 1'b0;
            ch_oh       <= '0;
            md_out      <= '1;
            md_tri      <= '1;
            HOSTRDDATA  <= '0;
            HOSTMIIMRDY <= 1'b1;
            HOSTMIIMERR <= 1'b0;
        end else begin
            HOSTMIIMERR <= 1'b0;
            case (state)
                MIIM_IDLE: begin
                    if (HOSTREQ && HOSTMIIMSEL) begin
                        if (legal) begin
                            state       <= MIIM_SHIFT_LO;
                            HOSTMIIMRDY <= 1'b0;
                            ch_oh       <= oh_next;
                            is_rd       <= req_rd;
                            bit_cnt     <= 6'(NBITS - 1);
                            frame       <= {frame_next[62:0], 1'b1};
                            md_out      <= ~oh_next | {NUM_EMAC{frame_next[63]}};
                            md_tri      <= ~oh_next;
                        end else begin
                            HOSTMIIMERR <= 1'b1;
                        end
                    end
                end
                MIIM_SHIFT_LO: begin
                    if (rise_tick) begin
                        state    <= MIIM_SHIFT_HI;
                        rd_shift <= {rd_shift[14:0], mdin_sel};
                    end
                end
                MIIM_SHIFT_HI: begin
                    if (fall_tick) begin
                        if (bit_cnt == '0) begin
                            state  <= MIIM_DONE;
                            md_out <= '1;
                            md_tri <= '1;
                        end else begin
                            state   <= MIIM_SHIFT_LO;
                            bit_cnt <= next_cnt;
                            frame   <= {frame[62:0], 1'b1};
                            md_out  <= ~ch_oh | {NUM_EMAC{frame[63]}};
                            // Reads hand the line to the PHY from the first TA bit onward.
                            md_tri  <= ~ch_oh | {NUM_EMAC{is_rd && (next_cnt <= REL_CNT)}};
                        end
                    end
                end
                MIIM_DONE: begin
                    state       <= MIIM_IDLE;
                    HOSTMIIMRDY <= 1'b1;
                    ch_oh       <= '0;
                    if (is_rd) begin
                        HOSTRDDATA <= rd_shift;
                    end
                end
                default: state <= MIIM_IDLE;
            endcase
        end
    end

    assign EMACPHYMCLKOUT = ch_oh & {NUM_EMAC{mdc}};
    assign EMACPHYMDOUT   = md_out;
    assign EMACPHYMDTRI   = md_tri;

endmodule

// File: tb/tb_x_emac_miim_host.sv
// tb/tb_x_emac_miim_host.sv - self-checking bench for x_emac_miim_host
module tb_x_emac_miim_host;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        msel;
    logic [1:0]  emacsel;
    logic [1:0]  opcode;
    logic [9:0]  addr;
    logic [15:0] wrdata;
    logic [2:0]  mdin_w;
    int          dsel;

    logic [15:0] rddata_a, rddata_b;
    logic        rdy_a, rdy_b, err_a, err_b;
    logic [1:0]  mclk_a, mdout_a, mdtri_a;
    logic [2:0]  mclk_b, mdout_b, mdtri_b;
    logic        req_a, req_b;

    logic [2:0]  mclk_w, mdout_w, mdtri_w;
    logic [15:0] rddata_w;
    logic        rdy_w, err_w;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_rd [2];

    always #5 clk = ~clk;

    assign req_a = req && (dsel == 0);
    assign req_b = req && (dsel == 1);

    x_emac_miim_host #(.NUM_EMAC(2), .CLK_DIV(2), .PREAMBLE_EN(1)) dut_a (
        .HOSTCLK(clk), .RESET(rst), .HOSTREQ(req_a), .HOSTMIIMSEL(msel),
        .HOSTEMACSEL(emacsel[0:0]), .HOSTOPCODE(opcode), .HOSTADDR(addr),
        .HOSTWRDATA(wrdata), .HOSTRDDATA(rddata_a), .HOSTMIIMRDY(rdy_a),
        .HOSTMIIMERR(err_a), .EMACPHYMCLKOUT(mclk_a), .EMACPHYMDOUT(mdout_a),
        .EMACPHYMDTRI(mdtri_a), .PHYEMACMDIN(mdin_w[1:0])
    );

    x_emac_miim_host #(.NUM_EMAC(3), .CLK_DIV(3), .PREAMBLE_EN(0)) dut_b (
        .HOSTCLK(clk), .RESET(rst), .HOSTREQ(req_b), .HOSTMIIMSEL(msel),
        .HOSTEMACSEL(emacsel), .HOSTOPCODE(opcode), .HOSTADDR(addr),
        .HOSTWRDATA(wrdata), .HOSTRDDATA(rddata_b), .HOSTMIIMRDY(rdy_b),
        .HOSTMIIMERR(err_b), .EMACPHYMCLKOUT(mclk_b), .EMACPHYMDOUT(mdout_b),
        .EMACPHYMDTRI(mdtri_b), .PHYEMACMDIN(mdin_w)
    );

    // Absent third channel of dut_a reads as an idle channel.
    always_comb begin
        if (dsel == 0) begin
            mclk_w = {1'b0, mclk_a}; mdout_w = {1'b1, mdout_a}; mdtri_w = {1'b1, mdtri_a};
            rddata_w = rddata_a; rdy_w = rdy_a; err_w = err_a;
        end else begin
            mclk_w = mclk_b; mdout_w = mdout_b; mdtri_w = mdtri_b;
            rddata_w = rddata_b; rdy_w = rdy_b; err_w = err_b;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_dut(input int d);
        dsel = d;
        @(negedge clk);
    endtask

    // One frame on the current DUT; busy_at injects a second request, abort_bit resets mid-frame.
    task automatic run_frame(input int ch, input logic [1:0] op, input logic [4:0] phy,
                             input logic [4:0] rg, input logic [15:0] data,
                             input logic [15:0] rd_val, input int busy_at, input int abort_bit);
        int          cd, nbits, total, b;
        logic        hi, driven;
        logic [63:0] exp_frame;
        logic [2:0]  exp_tri, exp_out, dc;
        cd        = (dsel == 0) ? 2 : 3;
        nbits     = (dsel == 0) ? 64 : 32;
        total     = nbits * 2 * cd;
        exp_frame = {32'hFFFF_FFFF, 2'b01, op, phy, rg, (op == 2'b01) ? 2'b10 : 2'b00, data};
        emacsel = 2'(ch); opcode = op; addr = {phy, rg}; wrdata = data; msel = 1'b1; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        for (int t = 1; t <= total; t++) begin
            b      = (t - 1) / (2 * cd);
            hi     = ((t - 1) % (2 * cd)) >= cd;
            driven = (op == 2'b01) || (b < nbits - 18);
            mdin_w = 3'b111;
            if (op == 2'b10 && b >= nbits - 16) mdin_w[ch] = rd_val[nbits - 1 - b];
            exp_tri = 3'b111; exp_out = 3'b111; dc = 3'b000;
            if (driven) begin
                exp_tri[ch] = 1'b0;
                exp_out[ch] = exp_frame[nbits - 1 - b];
            end else begin
                dc[ch] = 1'b1;
            end
            check("busy_ctl", {rdy_w, err_w}, 2'b00);
            check("mdc", mclk_w, hi ? (3'b001 << ch) : 3'b000);
            check("mdtri", mdtri_w, exp_tri);
            check("mdout", mdout_w | dc, exp_out | dc);
            if (t == busy_at) begin
                req = 1'b1; emacsel = 2'($urandom_range(0, 1)); opcode = 2'(3 - op);
                addr = 10'($urandom); wrdata = 16'($urandom);
            end
            if (t == busy_at + 1) req = 1'b0;
            if (abort_bit > 0 && t == abort_bit * 2 * cd + cd + 1) begin
                rst = 1'b1;
                #1;
                check("abort_mdc", mclk_w, 3'b000);
                check("abort_mdtri", mdtri_w, 3'b111);
                check("abort_ctl", {rdy_w, err_w}, 2'b10);
                check("abort_rddata", rddata_w, 16'h0000);
                exp_rd[0] = 16'h0; exp_rd[1] = 16'h0;
                mdin_w = 3'b111;
                return;
            end
            @(negedge clk);
        end
        mdin_w = 3'b111;
        check("done_ctl", {rdy_w, err_w}, 2'b00);
        check("done_mdc", mclk_w, 3'b000);
        check("done_mdtri", mdtri_w, 3'b111);
        check("done_mdout", mdout_w, 3'b111);
        @(negedge clk);
        if (op == 2'b10) exp_rd[dsel] = rd_val;
        check("ready_ctl", {rdy_w, err_w}, 2'b10);
        check("rddata", rddata_w, exp_rd[dsel]);
    endtask

    task automatic err_req(input int ch, input logic [1:0] op, input logic sel);
        emacsel = 2'(ch); opcode = op; msel = sel; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        check("err_pulse", {rdy_w, err_w}, {1'b1, sel});
        check("err_mdc", mclk_w, 3'b000);
        @(negedge clk);
        check("err_after", {rdy_w, err_w}, 2'b10);
        check("err_mdc2", mclk_w, 3'b000);
        check("err_mdtri", mdtri_w, 3'b111);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; msel = 1'b0; emacsel = '0; opcode = '0; addr = '0;
        wrdata = '0; mdin_w = 3'b111; dsel = 0;
        exp_rd[0] = 16'h0; exp_rd[1] = 16'h0;
        for (int d = 0; d < 2; d++) begin
            dsel = d;
            #1;
            check("rst_ctl", {rdy_w, err_w}, 2'b10);
            check("rst_rddata", rddata_w, 16'h0000);
            check("rst_mdc", mclk_w, 3'b000);
            check("rst_mdout", mdout_w, 3'b111);
            check("rst_mdtri", mdtri_w, 3'b111);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        set_dut(0);

        run_frame(1, 2'b01, 5'h01, 5'h04, 16'hA5C3, 16'h0, 0, 0);
        run_frame(0, 2'b10, 5'h02, 5'h01, 16'h0, 16'h1234, 0, 0);
        err_req(0, 2'b00, 1'b1);
        err_req(1, 2'b11, 1'b1);
        err_req(0, 2'b01, 1'b0);

        run_frame(int'($urandom_range(0, 1)), 2'b01, 5'($urandom), 5'($urandom),
                  16'($urandom), 16'h0, 10, 0);
        check("busy_idle_ctl", {rdy_w, err_w}, 2'b10);
        check("busy_idle_mdc", mclk_w, 3'b000);
        @(negedge clk);

        for (int k = 0; k < 3; k++) begin
            run_frame(int'($urandom_range(0, 1)), $urandom_range(0, 1) ? 2'b10 : 2'b01,
                      5'($urandom), 5'($urandom), 16'($urandom), 16'($urandom), 0, 0);
        end

        run_frame(0, 2'b10, 5'h03, 5'h02, 16'h0, 16'hBEEF, 0, 20);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_frame(1, 2'b01, 5'($urandom), 5'($urandom), 16'($urandom), 16'h0, 0, 0);

        set_dut(1);
        run_frame(int'($urandom_range(0, 2)), 2'b01, 5'($urandom), 5'($urandom),
                  16'($urandom), 16'h0, 0, 0);
        run_frame(2, 2'b10, 5'($urandom), 5'($urandom), 16'h0, 16'($urandom), 0, 0);
        err_req(3, 2'b01, 1'b1);
        err_req(1, 2'b00, 1'b1);
        run_frame(int'($urandom_range(0, 2)), 2'b10, 5'($urandom), 5'($urandom),
                  16'h0, 16'($urandom), 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
